// File: rtl/bsram_cpu8.sv
// ============================================================================
//  Module   : bsram_cpu8
//  Purpose  : 8-bit accumulator CPU that executes from an external 8 KiB
//             simple-dual-port block RAM (port A write, port B read) and
//             writes characters into a 1 KiB write-only VRAM. Program flow
//             can be paced to the display through the vsync input (WVS).
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             dout               - RAM port-B read data (1 cycle after ceb)
//             vsync              - asynchronous display vertical sync level
//             din/ada/cea        - RAM port-A write data/address/strobe
//             ceb/adb            - RAM port-B read enable/address
//             v_din/v_ada/v_cea  - VRAM write data/address/strobe
//  Config   : VSYNC_SYNC_EN - when defined, vsync passes a 2-flop
//             synchroniser before edge detection (WVS release 3 cycles
//             after the raw edge instead of 1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsram_cpu8 #(
    parameter int                ADDR_W   = 13,
    parameter int                VADDR_W  = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = 13'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         dout,
    input  logic               vsync,
    output logic [7:0]         din,
    output logic [ADDR_W-1:0]  ada,
    output logic               cea,
    output logic               ceb,
    output logic [ADDR_W-1:0]  adb,
    output logic [VADDR_W-1:0] v_ada,
    output logic               v_cea,
    output logic [7:0]         v_din
);

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_OP1   = 3'd1,
        ST_OP2   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_MEMRD = 3'd4,
        ST_VWAIT = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    localparam logic [7:0] c_op_lda_i = 8'h01;
    localparam logic [7:0] c_op_lda_a = 8'h02;
    localparam logic [7:0] c_op_sta   = 8'h03;
    localparam logic [7:0] c_op_ldx_i = 8'h04;
    localparam logic [7:0] c_op_inx   = 8'h05;
    localparam logic [7:0] c_op_add_i = 8'h06;
    localparam logic [7:0] c_op_cmp_i = 8'h07;
    localparam logic [7:0] c_op_jmp   = 8'h08;
    localparam logic [7:0] c_op_bne   = 8'h09;
    localparam logic [7:0] c_op_stv   = 8'h0A;
    localparam logic [7:0] c_op_stvx  = 8'h0B;
    localparam logic [7:0] c_op_wvs   = 8'h0C;
    localparam logic [7:0] c_op_dex   = 8'h0D;
    localparam logic [7:0] c_op_txa   = 8'h0E;
    localparam logic [7:0] c_op_hlt   = 8'hFF;

    // Architectural and sequencing state
    state_t              r_state, w_state;
    logic                r_boot,  w_boot;   // first cycle after reset: arm fetch
    logic                r_issue, w_issue;  // read request visible this cycle
    logic [ADDR_W-1:0]   r_adb,   w_adb;
    logic [ADDR_W-1:0]   r_pc,    w_pc;
    logic [7:0]          r_op,    w_op;
    logic [7:0]          r_lo,    w_lo;     // low operand, or LDA abs data
    logic [ADDR_W-9:0]   r_hi,    w_hi;     // only address-relevant bits kept
    logic [7:0]          r_a,     w_a;
    logic [7:0]          r_x,     w_x;
    logic                r_z,     w_z;
    logic                r_c,     w_c;
    logic [7:0]          r_din,   w_din;
    logic [ADDR_W-1:0]   r_ada,   w_ada;
    logic                r_cea,   w_cea;
    logic [7:0]          r_vdin,  w_vdin;
    logic [VADDR_W-1:0]  r_vada,  w_vada;
    logic                r_vcea,  w_vcea;

    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_abs;
    logic [ADDR_W-1:0]   w_target;
    logic [8:0]          w_sum;
    logic [7:0]          w_x_inc;
    logic [7:0]          w_x_dec;
    logic                w_vs_rise;

    assign w_pc_inc = r_pc + 1'b1;          // natural wrap 1FFF -> 0000
    assign w_abs    = {r_hi, r_lo};
    assign w_sum    = {1'b0, r_a} + {1'b0, r_lo};
    assign w_x_inc  = r_x + 8'd1;
    assign w_x_dec  = r_x - 8'd1;

    // vsync edge detection; only looked at while in VWAIT, so edges that
    // happen before the WVS wait starts are simply never observed.
`ifdef VSYNC_SYNC_EN
    logic r_vs_meta, r_vs_sync, r_vs_prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end
    assign w_vs_rise = r_vs_sync & ~r_vs_prev;
`else
    logic r_vs_prev;
    always_ff @(posedge clk) begin
        if (rst) r_vs_prev <= 1'b0;
        else     r_vs_prev <= vsync;
    end
    assign w_vs_rise = vsync & ~r_vs_prev;
`endif

    function automatic logic f_has_operand(input logic [7:0] op);
        case (op)
            c_op_lda_i, c_op_lda_a, c_op_sta,  c_op_ldx_i, c_op_add_i,
            c_op_cmp_i, c_op_jmp,   c_op_bne,  c_op_stv,   c_op_stvx: return 1'b1;
            default:                                                  return 1'b0;
        endcase
    endfunction

    function automatic logic f_two_operands(input logic [7:0] op);
        case (op)
            c_op_lda_a, c_op_sta, c_op_jmp, c_op_bne, c_op_stv, c_op_stvx: return 1'b1;
            default:                                                     return 1'b0;
        endcase
    endfunction

    // Every read is two cycles: an issue cycle (ceb high) and a capture
    // cycle. The issue for the next byte is registered on the capture edge,
    // so back-to-back bytes cost exactly two cycles each.
    always_comb begin
        w_state  = r_state;
        w_boot   = 1'b0;
        w_issue  = 1'b0;
        w_adb    = r_adb;
        w_pc     = r_pc;
        w_op     = r_op;
        w_lo     = r_lo;
        w_hi     = r_hi;
        w_a      = r_a;
        w_x      = r_x;
        w_z      = r_z;
        w_c      = r_c;
        w_din    = r_din;
        w_ada    = r_ada;
        w_cea    = 1'b0;
        w_vdin   = r_vdin;
        w_vada   = r_vada;
        w_vcea   = 1'b0;
        w_target = r_pc;
        case (r_state)
            ST_FETCH: begin
                if (r_boot) begin
                    w_issue = 1'b1;
                    w_adb   = r_pc;
                end else if (!r_issue) begin
                    w_op = dout;
                    w_pc = w_pc_inc;
                    if (dout == c_op_hlt) begin
                        w_state = ST_HALT;
                    end else if (f_has_operand(dout)) begin
                        w_state = ST_OP1;
                        w_issue = 1'b1;
                        w_adb   = w_pc_inc;
                    end else begin
                        w_state = ST_EXEC;
                    end
                end
            end
            ST_OP1: begin
                if (!r_issue) begin
                    w_lo = dout;
                    w_pc = w_pc_inc;
                    if (f_two_operands(r_op)) begin
                        w_state = ST_OP2;
                        w_issue = 1'b1;
                        w_adb   = w_pc_inc;
                    end else begin
                        w_state = ST_EXEC;
                    end
                end
            end
            ST_OP2: begin
                if (!r_issue) begin
                    w_hi = dout[ADDR_W-9:0];
                    w_pc = w_pc_inc;
                    if (r_op == c_op_lda_a) begin
                        w_state = ST_MEMRD;
                        w_issue = 1'b1;
                        w_adb   = {dout[ADDR_W-9:0], r_lo};
                    end else begin
                        w_state = ST_EXEC;
                    end
                end
            end
            ST_MEMRD: begin
                // Loaded byte lands in the operand register so EXEC treats
                // LDA abs exactly like LDA immediate.
                if (!r_issue) begin
                    w_lo    = dout;
                    w_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (r_op)
                    c_op_lda_i, c_op_lda_a: begin
                        w_a = r_lo;
                        w_z = (r_lo == 8'd0);
                    end
                    c_op_sta: begin
                        w_cea = 1'b1;
                        w_ada = w_abs;
                        w_din = r_a;
                    end
                    c_op_ldx_i: begin
                        w_x = r_lo;
                        w_z = (r_lo == 8'd0);
                    end
                    c_op_inx: begin
                        w_x = w_x_inc;
                        w_z = (w_x_inc == 8'd0);
                    end
                    c_op_dex: begin
                        w_x = w_x_dec;
                        w_z = (w_x_dec == 8'd0);
                    end
                    c_op_txa: begin
                        w_a = r_x;
                        w_z = (r_x == 8'd0);
                    end
                    c_op_add_i: begin
                        w_a = w_sum[7:0];
                        w_c = w_sum[8];
                        w_z = (w_sum[7:0] == 8'd0);
                    end
                    c_op_cmp_i: begin
                        w_z = (r_a == r_lo);
                        w_c = (r_a >= r_lo);
                    end
                    c_op_jmp: w_target = w_abs;
                    c_op_bne: if (!r_z) w_target = w_abs;
                    c_op_stv: begin
                        w_vcea = 1'b1;
                        w_vada = w_abs[VADDR_W-1:0];
                        w_vdin = r_a;
                    end
                    c_op_stvx: begin
                        w_vcea = 1'b1;
                        w_vada = w_abs[VADDR_W-1:0] + VADDR_W'(r_x);
                        w_vdin = r_a;
                    end
                    default: ;
                endcase
                if (r_op == c_op_wvs) begin
                    w_state = ST_VWAIT;
                end else begin
                    w_state = ST_FETCH;
                    w_issue = 1'b1;
                    w_adb   = w_target;
                    w_pc    = w_target;
                end
            end
            ST_VWAIT: begin
                if (w_vs_rise) begin
                    w_state = ST_FETCH;
                    w_issue = 1'b1;
                    w_adb   = r_pc;
                end
            end
            ST_HALT: ;
            default: w_state = ST_HALT;
        endcase
    end

    // Strobes are registered on the edge that leaves EXEC, so a reset
    // arriving on that edge suppresses them entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_boot  <= 1'b1;
            r_issue <= 1'b0;
            r_adb   <= '0;
            r_pc    <= RESET_PC;
            r_op    <= 8'd0;
            r_lo    <= 8'd0;
            r_hi    <= '0;
            r_a     <= 8'd0;
            r_x     <= 8'd0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
            r_din   <= 8'd0;
            r_ada   <= '0;
            r_cea   <= 1'b0;
            r_vdin  <= 8'd0;
            r_vada  <= '0;
            r_vcea  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_boot  <= w_boot;
            r_issue <= w_issue;
            r_adb   <= w_adb;
            r_pc    <= w_pc;
            r_op    <= w_op;
            r_lo    <= w_lo;
            r_hi    <= w_hi;
            r_a     <= w_a;
            r_x     <= w_x;
            r_z     <= w_z;
            r_c     <= w_c;
            r_din   <= w_din;
            r_ada   <= w_ada;
            r_cea   <= w_cea;
            r_vdin  <= w_vdin;
            r_vada  <= w_vada;
            r_vcea  <= w_vcea;
        end
    end

    assign ceb   = r_issue;
    assign adb   = r_adb;
    assign din   = r_din;
    assign ada   = r_ada;
    assign cea   = r_cea;
    assign v_din = r_vdin;
    assign v_ada = r_vada;
    assign v_cea = r_vcea;

endmodule

`default_nettype wire

// File: tb/tb_bsram_cpu8.sv
// ============================================================================
//  Module   : tb_bsram_cpu8
//  Purpose  : Self-checking bench for bsram_cpu8. A behavioural block RAM
//             feeds the CPU; expected RAM/VRAM write events are queued when
//             a program is loaded and compared as strobes appear.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bsram_cpu8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  dout;
    logic        vsync;
    logic [7:0]  din;
    logic [12:0] ada;
    logic        cea;
    logic        ceb;
    logic [12:0] adb;
    logic [9:0]  v_ada;
    logic        v_cea;
    logic [7:0]  v_din;

    bsram_cpu8 dut (
        .clk   (clk),
        .rst   (rst),
        .dout  (dout),
        .vsync (vsync),
        .din   (din),
        .ada   (ada),
        .cea   (cea),
        .ceb   (ceb),
        .adb   (adb),
        .v_ada (v_ada),
        .v_cea (v_cea),
        .v_din (v_din)
    );

    always #5 clk = ~clk;

    // Behavioural simple-dual-port RAM, one-cycle read latency
    logic [7:0] mem [0:8191];
    always @(posedge clk) begin
        if (cea) mem[ada] <= din;
        if (ceb) dout <= mem[adb];
    end

    // Free-running vsync (100 ns period) when enabled, offset from clk edges
    logic vs_en = 1'b0;
    int   vs_rise_cnt = 0;
    time  t_vs_rise = 0;
    initial begin
        vsync = 1'b0;
        #3;
        forever begin
            #50;
            vsync = vs_en ? ~vsync : 1'b0;
        end
    end
    always @(posedge vsync) begin
        vs_rise_cnt++;
        t_vs_rise = $time;
    end

    typedef struct packed {
        logic        vram;
        logic [12:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t        sb_q[$];
    ev_t        mon_e;
    logic [7:0] prog_q[$];
    int         n_total = 0;
    int         n_bad   = 0;
    int         rd_cnt  [0:8191];
    time        t_first [0:8191];
    int         vs_base;
    int         vs_seen;
    time        wvs_lat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp_ev(input logic vr, input logic [12:0] a, input logic [7:0] d);
        ev_t e;
        e.vram = vr;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Output monitor: scoreboard pops on strobes, read bookkeeping on ceb
    always @(negedge clk) begin
        if (cea === 1'b1 || v_cea === 1'b1) begin
            chk("strobe_excl", 32'(cea & v_cea), 32'd0);
            chk("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("sb_kind", 32'(v_cea), 32'(mon_e.vram));
                chk("sb_addr", v_cea ? 32'(v_ada) : 32'(ada), 32'(mon_e.addr));
                chk("sb_data", v_cea ? 32'(v_din) : 32'(din), 32'(mon_e.data));
            end
        end
        if (ceb === 1'b1) begin
            if (rd_cnt[adb] == 0) begin
                t_first[adb] = $time;
                if (adb == 13'h0004) vs_base = vs_rise_cnt;
                if (adb == 13'h0005) begin
                    vs_seen = vs_rise_cnt - vs_base;
                    wvs_lat = $time - t_vs_rise;
                end
            end
            rd_cnt[adb]++;
        end
    end

    task automatic prep();
        rst = 1'b1;
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = 8'hFF;
            rd_cnt[i]  = 0;
            t_first[i] = 0;
        end
        vs_seen = 0;
        wvs_lat = 64'd99999;
        prog_q.delete();
    endtask

    task automatic load_at(input int base);
        for (int i = 0; i < prog_q.size(); i++) mem[(base + i) % 8192] = prog_q[i];
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ram"},  32'({din, ada, cea}), 32'd0);
        chk({tag, "_rd"},   32'({ceb, adb}), 32'd0);
        chk({tag, "_vram"}, 32'({v_din, v_ada, v_cea}), 32'd0);
    endtask

    task automatic wait_first_read(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ceb !== 1'b1 && n < 4);
        chk({tag, "_ceb"}, 32'(ceb), 32'd1);
        chk({tag, "_adb"}, 32'(adb), 32'd0);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        check_outputs_zero("rst_out");
        rst = 1'b0;
        wait_first_read("first_rd");
    endtask

    task automatic run_to_halt(input int limit);
        int idle = 0;
        int cyc  = 0;
        while (idle < 40 && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (ceb === 1'b1) idle = 0;
            else              idle++;
        end
        chk("run_idle", 32'(idle >= 40), 32'd1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        // 1: LDA #41, STV 0000, HLT
        prep();
        prog_q = '{8'h01, 8'h41, 8'h0A, 8'h00, 8'h00, 8'hFF};
        load_at(0);
        exp_ev(1'b1, 13'h000, 8'h41);
        repeat (2) @(posedge clk);
        release_rst();
        run_to_halt(2000);
        chk("p1_no_read_past_hlt", 32'(rd_cnt[6]), 32'd0);

        // 2: STA 1000, reload via LDA abs, STV 0005
        prep();
        prog_q = '{8'h01, 8'h5A, 8'h03, 8'h00, 8'h10, 8'h01, 8'h00,
                   8'h02, 8'h00, 8'h10, 8'h0A, 8'h05, 8'h00, 8'hFF};
        load_at(0);
        exp_ev(1'b0, 13'h1000, 8'h5A);
        exp_ev(1'b1, 13'h005, 8'h5A);
        release_rst();
        run_to_halt(2000);
        chk("sta_cycles", 32'((t_first[5] - t_first[2]) / 10), 32'd7);
        chk("lda_abs_cycles", 32'((t_first[10] - t_first[7]) / 10), 32'd9);

        // 3: DEX loop three times then HLT
        prep();
        prog_q = '{8'h04, 8'h03, 8'h0D, 8'h09, 8'h02, 8'h00, 8'hFF};
        load_at(0);
        release_rst();
        run_to_halt(2000);
        chk("ldx_cycles", 32'((t_first[2] - t_first[0]) / 10), 32'd5);
        chk("dex_count", 32'(rd_cnt[2]), 32'd3);
        chk("halt_fetch", 32'(rd_cnt[6]), 32'd1);
        chk("p3_no_read_past_hlt", 32'(rd_cnt[7]), 32'd0);

        // 4a: ADD with carry out, STV 0001
        prep();
        prog_q = '{8'h01, 8'hF0, 8'h06, 8'h20, 8'h0A, 8'h01, 8'h00, 8'hFF};
        load_at(0);
        exp_ev(1'b1, 13'h001, 8'h10);
        release_rst();
        run_to_halt(2000);

        // 4b: CMP equal sets Z, so BNE must fall through to STV 0003
        prep();
        prog_q = '{8'h01, 8'h10, 8'h07, 8'h10, 8'h09, 8'h0D, 8'h00,
                   8'h0A, 8'h03, 8'h00, 8'hFF, 8'hFF, 8'hFF,
                   8'h0A, 8'h04, 8'h00, 8'hFF};
        load_at(0);
        exp_ev(1'b1, 13'h003, 8'h10);
        release_rst();
        run_to_halt(2000);
        chk("bne_not_taken", 32'(rd_cnt[13]), 32'd0);

        // 5: WVS then STVX 0000 with X=2, vsync running
        prep();
        prog_q = '{8'h04, 8'h02, 8'h01, 8'h33, 8'h0C, 8'h0B, 8'h00, 8'h00, 8'hFF};
        load_at(0);
        exp_ev(1'b1, 13'h002, 8'h33);
        vs_en = 1'b1;
        release_rst();
        run_to_halt(3000);
        vs_en = 1'b0;
        chk("wvs_rise_seen", 32'(vs_seen >= 1), 32'd1);
        chk("wvs_latency", 32'(wvs_lat <= 45), 32'd1);

        // 6: address truncation and 10-bit STVX wrap, STA upper bits ignored
        prep();
        prog_q = '{8'h01, 8'h77, 8'h0A, 8'h05, 8'hFC, 8'h04, 8'h02,
                   8'h0B, 8'hFF, 8'h03, 8'h03, 8'hE1, 8'hE0, 8'hFF};
        load_at(0);
        exp_ev(1'b1, 13'h005, 8'h77);
        exp_ev(1'b1, 13'h001, 8'h77);
        exp_ev(1'b0, 13'h00E1, 8'h77);
        release_rst();
        run_to_halt(2000);

        // 7: PC wraps 1FFF -> 0000 mid-instruction
        prep();
        prog_q = '{8'h08, 8'hFE, 8'h1F, 8'hFF};
        load_at(0);
        prog_q = '{8'h0A, 8'h09};
        load_at(8190);
        exp_ev(1'b1, 13'h009, 8'h00);
        release_rst();
        run_to_halt(2000);
        chk("wrap_rd0", 32'(rd_cnt[0]), 32'd2);

        // 8: reset during STA execution
        prep();
        prog_q = '{8'h01, 8'h5A, 8'h03, 8'h00, 8'h10, 8'h01, 8'h00,
                   8'h02, 8'h00, 8'h10, 8'h0A, 8'h05, 8'h00, 8'hFF};
        load_at(0);
        release_rst();
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(ceb === 1'b1 && adb == 13'h0004) && n < 100);
            chk("sta_reached", 32'(ceb === 1'b1 && adb == 13'h0004), 32'd1);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("mid_rst");
        rst = 1'b0;
        exp_ev(1'b0, 13'h1000, 8'h5A);
        exp_ev(1'b1, 13'h005, 8'h5A);
        wait_first_read("post_rst_rd");
        run_to_halt(2000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
